// File: rtl/fir_serial_mac.sv
// Serial FIR MAC: one signed multiplier walks a latched tap/coef snapshot over DEPTH cycles.
// Build option FIR_MAC_SAT_EN: saturating accumulator instead of modulo-2^ACC_WIDTH wrap.
module fir_serial_mac #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int ACC_WIDTH = 2*WIDTH + $clog2(DEPTH)
) (
  input  logic                                 clk,
  input  logic                                 rstn,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DEPTH-1:0][WIDTH-1:0]          taps,
  input  logic [DEPTH-1:0][WIDTH-1:0]          coefs,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic signed [ACC_WIDTH-1:0]          dout,
  output logic                                 busy
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PROD_W = 2*WIDTH;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                      state, state_nxt;
  logic        [IDX_W-1:0]     idx_p0;
  logic signed [WIDTH-1:0]     tap_snap_p0  [DEPTH];
  logic signed [WIDTH-1:0]     coef_snap_p0 [DEPTH];
  logic signed [PROD_W-1:0]    prod_p0;
  logic signed [ACC_WIDTH-1:0] acc_p1;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  logic                        last_term;

`ifdef FIR_MAC_SAT_EN
  localparam int EXT_W = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;

  // Sum at a width that cannot overflow, then clamp back into the accumulator range.
  function automatic logic signed [ACC_WIDTH-1:0] acc_step(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [PROD_W-1:0]    p
  );
    logic signed [EXT_W-1:0] s;
    logic signed [EXT_W-1:0] max_e;
    logic signed [EXT_W-1:0] min_e;
    s     = $signed({{(EXT_W-ACC_WIDTH){a[ACC_WIDTH-1]}}, a})
          + $signed({{(EXT_W-PROD_W){p[PROD_W-1]}}, p});
    max_e = $signed({{(EXT_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}});
    min_e = $signed({{(EXT_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}});
    if (s > max_e)      acc_step = max_e[ACC_WIDTH-1:0];
    else if (s < min_e) acc_step = min_e[ACC_WIDTH-1:0];
    else                acc_step = s[ACC_WIDTH-1:0];
  endfunction
`else
  function automatic logic signed [ACC_WIDTH-1:0] acc_step(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [PROD_W-1:0]    p
  );
    acc_step = a + ACC_WIDTH'(p);
  endfunction
`endif

  // Stage p0: multiply the snapshot pair selected by the running index
  always_comb begin
    prod_p0   = PROD_W'(tap_snap_p0[idx_p0]) * PROD_W'(coef_snap_p0[idx_p0]);
    acc_nxt   = acc_step(acc_p1, prod_p0);
    last_term = (idx_p0 == IDX_W'(DEPTH-1));
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (last_term) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: snapshot capture, accumulation and result register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_p0 <= '0;
      acc_p1 <= '0;
      dout   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tap_snap_p0[i]  <= '0;
        coef_snap_p0[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            idx_p0 <= '0;
            acc_p1 <= '0;
            for (int i = 0; i < DEPTH; i++) begin
              tap_snap_p0[i]  <= $signed(taps[i]);
              coef_snap_p0[i] <= $signed(coefs[i]);
            end
          end
        end
        MAC: begin
          acc_p1 <= acc_nxt;
          idx_p0 <= idx_p0 + 1'b1;
          if (last_term) dout <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Directed bench for fir_serial_mac: default-width instance plus a 32-bit accumulator instance.
module tb_fir_serial_mac;

  logic                    clk;
  logic                    rstn;
  logic                    in_valid;
  logic                    out_ready;
  logic [7:0][15:0]        taps;
  logic [7:0][15:0]        coefs;
  logic                    in_ready, out_valid, busy;
  logic signed [34:0]      dout;
  logic                    in_ready32, out_valid32, busy32;
  logic signed [31:0]      dout32;

  int checks = 0;
  int errors = 0;

  fir_serial_mac #(.WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .taps(taps), .coefs(coefs), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .busy(busy)
  );

  fir_serial_mac #(.WIDTH(16), .DEPTH(8), .ACC_WIDTH(32)) dut32 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready32),
    .taps(taps), .coefs(coefs), .out_valid(out_valid32), .out_ready(out_ready),
    .dout(dout32), .busy(busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance until out_valid rises, returning the number of edges taken.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
  endtask

  task automatic fill(input int tv, input int cv);
    for (int i = 0; i < 8; i++) begin
      taps[i]  = 16'(tv);
      coefs[i] = 16'(cv);
    end
  endtask

  int     lat;
  int     last_acc;
  int     n_acc;
  int     n_res;
  logic   was_ready;
  longint exp_q;

  initial begin
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    fill(0, 0);
    tick(); tick();
    rstn = 1'b1;
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_dout", dout, 0);

    // Basic sum: taps 1, coefs 1..8 -> 36
    for (int i = 0; i < 8; i++) begin
      taps[i]  = 16'd1;
      coefs[i] = 16'(i + 1);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    fill(99, 99);
    check("mac_busy", longint'(busy), 1);
    check("mac_in_ready", longint'(in_ready), 0);
    wait_valid(lat);
    check("basic_latency", lat, 8);
    check("basic_dout", dout, 36);
    check("basic_busy_done", longint'(busy), 1);

    // Backpressure: result held, new vectors ignored
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      fill(c + 7, 3);
      tick();
      check("bp_dout", dout, 36);
      check("bp_out_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", longint'(out_valid), 0);
    check("bp_release_ready", longint'(in_ready), 1);
    check("bp_dout_kept", dout, 36);
    out_ready = 1'b0;

    // Extreme negative values: 8 * 2^30 = 2^33; 32-bit instance overflows
    fill(-32768, -32768);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("ext_latency", lat, 8);
    check("ext_dout", dout, 64'sd8589934592);
`ifdef FIR_MAC_SAT_EN
    check("ovf32_dout", dout32, 64'sd2147483647);
`else
    check("ovf32_dout", dout32, 0);
`endif
    check("ovf32_valid", longint'(out_valid32), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Alternating +3/-3 taps against coefs of 5 cancel out
    for (int i = 0; i < 8; i++) begin
      taps[i]  = (i % 2 == 0) ? 16'd3 : 16'hFFFD;
      coefs[i] = 16'd5;
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("alt_dout", dout, 0);
    out_ready = 1'b1;
    tick();

    // Back-to-back with a fresh vector every cycle: taps all c+1, coefs 3 -> 24*(c+1)
    in_valid = 1'b1;
    last_acc = -1; n_acc = 0; n_res = 0; exp_q = 0;
    for (int c = 0; c < 40; c++) begin
      fill(c + 1, 3);
      was_ready = in_ready;
      tick();
      if (was_ready) begin
        if (last_acc >= 0) check("b2b_interval", c - last_acc, 10);
        last_acc = c;
        exp_q = 24 * (c + 1);
        n_acc++;
      end
      if (out_valid) begin
        check("b2b_dout", dout, exp_q);
        n_res++;
      end
    end
    in_valid = 1'b0;
    check("b2b_accepts", n_acc, 4);
    check("b2b_results", n_res, 4);
    out_ready = 1'b0;

    // Reset asserted for edge E4 of a computation
    fill(-32768, -32768);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("rst_mid_in_ready", longint'(in_ready), 1);
    check("rst_mid_out_valid", longint'(out_valid), 0);
    check("rst_mid_busy", longint'(busy), 0);
    check("rst_mid_dout", dout, 0);

    for (int i = 0; i < 8; i++) begin
      taps[i]  = 16'(i + 1);
      coefs[i] = 16'd2;
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("post_rst_latency", lat, 8);
    check("post_rst_dout", dout, 72);
    check("post_rst_dout32", dout32, 72);
    out_ready = 1'b1;
    tick();
    check("post_rst_idle", longint'(in_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_serial_mac.md
Name: fir_serial_mac

Overview:
- Downstream consumer of the tapped delay line. Takes one snapshot of the DEPTH-tap sample vector plus a matching coefficient vector and computes the FIR output y = sum over i of coef[i]*tap[i].
- Uses a single signed multiplier, time-multiplexed over DEPTH cycles.
- Valid/ready handshakes on both sides. Feeds the error/LMS-update stage of the adaptive filter.

Parameters:
- WIDTH, 16, bit width of each signed tap sample and each signed coefficient.
- DEPTH, 8, number of taps; must be >= 2.
- ACC_WIDTH, 2*WIDTH+$clog2(DEPTH), signed accumulator and output width; may be overridden narrower.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  taps/coefs valid.
- in_ready  output  1  block can accept a new vector.
- taps  input  [DEPTH-1:0][WIDTH-1:0]  signed samples; taps[0] is the newest.
- coefs  input  [DEPTH-1:0][WIDTH-1:0]  signed coefficients; coefs[i] pairs with taps[i].
- out_valid  output  1  dout holds a completed result.
- out_ready  input  1  consumer accepts dout.
- dout  output  ACC_WIDTH  signed FIR result.
- busy  output  1  high in MAC or DONE state.

Behaviour:
- Reset: rstn low at a rising edge forces the following, regardless of the current state:
  - state=IDLE
  - in_ready=1, out_valid=0, busy=0
  - dout=0, accumulator=0, index=0
  - internal tap/coef snapshot registers cleared
  - Reset mid-MAC or mid-DONE aborts the computation and drops the result with no partial output.
- States: IDLE, MAC, DONE, encoded in a registered FSM.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge E0: latch taps and coefs into snapshot registers, clear accumulator, index=0, go to MAC.
  - After latching, input ports may change freely.
- MAC:
  - in_ready=0, busy=1.
  - Each edge: acc <= acc + sext(snap_tap[index]*snap_coef[index]); index increments.
  - Product is full 2*WIDTH signed, sign-extended to ACC_WIDTH.
  - Exactly DEPTH accumulate edges (E1..E_DEPTH).
  - On the edge that adds index DEPTH-1: dout <= final sum, out_valid <= 1, go to DONE.
- DONE:
  - out_valid=1; dout is held stable until the handshake completes.
  - On out_valid&&out_ready: out_valid <= 0, go to IDLE, in_ready=1 the next cycle.
  - in_valid is ignored in MAC and DONE.
- Latency and throughput:
  - out_valid is first visible in the cycle after edge E_DEPTH, i.e. DEPTH cycles after acceptance.
  - Minimum accept-to-accept interval is DEPTH+2 cycles when out_ready is held high.
- Arithmetic:
  - Two's-complement throughout.
  - With the default ACC_WIDTH overflow cannot occur.
  - With a narrower ACC_WIDTH, behaviour is governed by the optional feature below.
- dout keeps its last value after the handshake until the next result is written; it is not cleared.

Optional Feature:
- Macro: FIR_MAC_SAT_EN.
- Defined: each accumulate step saturates to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. Once saturated, later terms continue from the clamped value.
- Undefined: the accumulator wraps modulo 2^ACC_WIDTH, with no saturation logic.
- Timing, handshake and latency are identical in both builds.

Test Plan:
- Basic sum. WIDTH=16, DEPTH=8, taps all 1, coefs 1..8 (coefs[i]=i+1); accept at E0. Required: out_valid rises after E8, dout=36, busy high from E1 through the handshake.
- Sign and extreme values. All taps=-32768, all coefs=-32768, default ACC_WIDTH=35. Required: dout=2^33=8589934592. Second run with taps alternating +3/-3 and coefs all 5: dout=0.
- Backpressure. After the result, hold out_ready=0 for 5 cycles while pulsing in_valid with new data. Required: dout stays stable, out_valid=1, in_ready=0, new data not taken. Then raise out_ready: handshake completes and in_ready=1 the next cycle.
- Back-to-back. Hold in_valid=1 and out_ready=1 with changing vectors. Required: accepts spaced exactly 10 cycles apart, each dout matches the vector present at its own accept edge.
- Overflow with ACC_WIDTH=32 and all-(-32768) inputs (true sum 2^33). Required: FIR_MAC_SAT_EN defined gives dout=2147483647; undefined gives dout=0.
- Reset mid-MAC. Drive rstn=0 at E4 of a computation. Required: next cycle state=IDLE, out_valid=0, dout=0, in_ready=1. A new accept then gives the correct result with no residue from the aborted sum.
